// File: rtl/ddr3_mem_resp_if.sv
// Command/status bundle between a DDR3 controller (master) and the memory responder (slave).
interface ddr3_mem_resp_if;
  logic        CKE_N;
  logic        CS_N;
  logic        RAS_N;
  logic        CAS_N;
  logic        WE_N;
  logic [2:0]  BA;
  logic [14:0] ADDR;
  logic [7:0]  BANK_OPEN;
  logic        CMD_ERR;

  modport master (
    output CKE_N, CS_N, RAS_N, CAS_N, WE_N, BA, ADDR,
    input  BANK_OPEN, CMD_ERR
  );

  modport slave (
    input  CKE_N, CS_N, RAS_N, CAS_N, WE_N, BA, ADDR,
    output BANK_OPEN, CMD_ERR
  );
endinterface

// File: rtl/ddr3_mem_resp.sv
// DDR3 x8 device-side responder: command decode, per-bank open rows, BL8 bursts on a reduced array.
// Define DDR3_RESP_CHECK_EN to enforce protocol rules (tRCD, bank state) and pulse CMD_ERR.
module ddr3_mem_resp #(
  parameter int CL       = 5,
  parameter int CWL      = 5,
  parameter int TRCD     = 3,
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 10
) (
  input  logic           CK,
  input  logic           RESET,
  ddr3_mem_resp_if.slave bus,
  inout  wire  [7:0]     DQ
);
  localparam int IDX_BITS = 3 + ROW_BITS + COL_BITS;
  localparam int MAX_LAT  = (CL > CWL) ? CL : CWL;
  localparam int LAT_W    = $clog2(MAX_LAT + 1);

  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_ZQC = 4'b0110;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  // state   | meaning
  // INIT    | waiting for ZQC, everything else ignored
  // READY   | accepting ACT/PRE/REF/MRS/ZQC/RD/WR
  // WLAT    | counting down write latency
  // WBURST  | capturing write beats 1..7
  // RLAT    | counting down read latency
  // RBURST  | driving read beats 1..7
  typedef enum logic [2:0] {
    ST_INIT, ST_READY, ST_WLAT, ST_WBURST, ST_RLAT, ST_RBURST
  } state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [2:0]          beat_q, beat_d;
  logic [2:0]          bank_q, bank_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                ap_q, ap_d;
  logic [7:0]          bank_open_q, bank_open_d;
  logic [ROW_BITS-1:0] open_row_q [8];
  logic [ROW_BITS-1:0] open_row_d [8];
  logic                cmd_err_q, cmd_err_d;
  logic                dq_oe_q, dq_oe_d;
  logic [7:0]          dq_out_q, dq_out_d;
  logic [7:0]          mem [2**IDX_BITS];

  logic [3:0]          cmd;
  logic [2:0]          cur_beat;
  logic [IDX_BITS-1:0] beat_idx;
  logic                mem_we;
  logic                trcd_ok;
  logic                rw_legal;
  logic                unused_addr;

  always_comb begin
    cmd = {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N};
    if (!bus.CKE_N || bus.CS_N) cmd = CMD_NOP;
  end

`ifdef DDR3_RESP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
  localparam int TRCD_W   = (TRCD > 1) ? $clog2(TRCD) : 1;

  logic [TRCD_W-1:0] trcd_q [8];
  logic [TRCD_W-1:0] trcd_d [8];

  // Under checking an ACT only takes effect on a closed bank, so that is when the timer reloads.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - 1'b1 : '0;
    end
    if (state_q == ST_READY && cmd == CMD_ACT && !bank_open_q[bus.BA]) begin
      trcd_d[bus.BA] = TRCD_W'(TRCD - 1);
    end
  end

  always_ff @(posedge CK) begin
    if (RESET) trcd_q <= '{default: '0};
    else       trcd_q <= trcd_d;
  end

  assign trcd_ok = (trcd_q[bus.BA] == '0);
`else
  localparam bit CHECK_EN = 1'b0;
  assign trcd_ok = 1'b1;
`endif

  assign rw_legal    = !CHECK_EN || (bank_open_q[bus.BA] && trcd_ok);
  assign unused_addr = ^bus.ADDR;

  // Beat 0 is addressed from the latency states, so only burst states contribute beat_q.
  assign cur_beat = (state_q == ST_WBURST || state_q == ST_RBURST) ? beat_q : 3'd0;
  assign beat_idx = {bank_q, open_row_q[bank_q], col_q[COL_BITS-1:3], col_q[2:0] + cur_beat};

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    bank_d      = bank_q;
    col_d       = col_q;
    ap_d        = ap_q;
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    cmd_err_d   = 1'b0;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    mem_we      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (cmd == CMD_ZQC) state_d = ST_READY;
      end
      ST_READY: begin
        case (cmd)
          CMD_ACT: begin
            if (CHECK_EN && bank_open_q[bus.BA]) begin
              cmd_err_d = 1'b1;
            end else begin
              bank_open_d[bus.BA] = 1'b1;
              open_row_d[bus.BA]  = bus.ADDR[ROW_BITS-1:0];
            end
          end
          CMD_PRE: begin
            if (bus.ADDR[10]) bank_open_d = '0;
            else              bank_open_d[bus.BA] = 1'b0;
          end
          CMD_REF: begin
            if (CHECK_EN && (|bank_open_q)) cmd_err_d = 1'b1;
          end
          CMD_WR, CMD_RD: begin
            if (!rw_legal) begin
              cmd_err_d = 1'b1;
            end else begin
              bank_d = bus.BA;
              col_d  = bus.ADDR[COL_BITS-1:0];
              ap_d   = bus.ADDR[10];
              if (cmd == CMD_WR) begin
                lat_d   = LAT_W'(CWL - 1);
                state_d = ST_WLAT;
              end else begin
                lat_d   = LAT_W'(CL - 1);
                state_d = ST_RLAT;
              end
            end
          end
          default: ;
        endcase
      end
      ST_WLAT, ST_RLAT: begin
        cmd_err_d = CHECK_EN && (cmd != CMD_NOP);
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          beat_d = 3'd1;
          if (state_q == ST_WLAT) begin
            mem_we  = 1'b1;
            state_d = ST_WBURST;
          end else begin
            dq_oe_d  = 1'b1;
            dq_out_d = mem[beat_idx];
            state_d  = ST_RBURST;
          end
        end
      end
      ST_WBURST, ST_RBURST: begin
        cmd_err_d = CHECK_EN && (cmd != CMD_NOP);
        beat_d    = beat_q + 3'd1;
        if (state_q == ST_WBURST) begin
          mem_we = 1'b1;
        end else begin
          dq_oe_d  = 1'b1;
          dq_out_d = mem[beat_idx];
        end
        if (beat_q == 3'd7) begin
          state_d = ST_READY;
          if (ap_q) bank_open_d[bank_q] = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      state_q     <= ST_INIT;
      lat_q       <= '0;
      beat_q      <= '0;
      bank_q      <= '0;
      col_q       <= '0;
      ap_q        <= 1'b0;
      bank_open_q <= '0;
      open_row_q  <= '{default: '0};
      cmd_err_q   <= 1'b0;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      bank_q      <= bank_d;
      col_q       <= col_d;
      ap_q        <= ap_d;
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      cmd_err_q   <= cmd_err_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  // Array is not reset; beats already captured before a reset stay stored.
  always_ff @(posedge CK) begin
    if (mem_we && !RESET) mem[beat_idx] <= DQ;
  end

  assign DQ            = dq_oe_q ? dq_out_q : 8'bz;
  assign bus.BANK_OPEN = bank_open_q;
  assign bus.CMD_ERR   = cmd_err_q;
endmodule

// File: tb/tb_ddr3_mem_resp.sv
// Directed plus randomized bench for ddr3_mem_resp against a cycle-indexed behavioural model.
module tb_ddr3_mem_resp;
  localparam int CL = 5, CWL = 5, TRCD = 3, ROW_BITS = 4, COL_BITS = 10;
`ifdef DDR3_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [3:0] C_MRS = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010, C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100, C_RD  = 4'b0101, C_ZQC = 4'b0110, C_NOP = 4'b0111;

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_dq_en;
  logic [7:0] tb_dq;
  wire  [7:0] dq;

  assign dq = tb_dq_en ? tb_dq : 8'bz;
  // Undriven DQ floats high, so a released bus reads back as 8'hff.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (dq[i]);
  end

  ddr3_mem_resp_if bus ();

  ddr3_mem_resp #(.CL(CL), .CWL(CWL), .TRCD(TRCD), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) dut (
    .CK   (clk),
    .RESET(rst),
    .bus  (bus),
    .DQ   (dq)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         m_ready;
  int         busy_until;
  logic [7:0] m_open;
  int         m_row [8];
  int         m_act [8];
  int         m_mem [int];
  int         exp_dq [int];
  int         wr_idx [int];
  int         close_at [int];
  int         wr_data_q [$];

  function automatic int arr_index(int ba, int row, int col, int k);
    int colk;
    colk = (col & ((1 << COL_BITS) - 8)) | ((col + k) & 7);
    return (ba << (ROW_BITS + COL_BITS)) | ((row % (1 << ROW_BITS)) << COL_BITS) | colk;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge: drive command (and write data when a beat is due), advance model, compare.
  task automatic step(input bit r, input logic [3:0] code, input int ba, input int addr,
                      input bit cke_n = 1'b1);
    int         e;
    int         lat;
    int         idx;
    bit         err;
    logic [3:0] c;
    e   = cyc;
    err = 1'b0;
    rst = r;
    bus.CKE_N = cke_n;
    {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N} = code;
    bus.BA   = 3'(ba);
    bus.ADDR = 15'(addr);
    tb_dq_en = 1'b0;
    if (!r && wr_idx.exists(e)) begin
      tb_dq    = (wr_data_q.size() > 0) ? 8'(wr_data_q.pop_front()) : 8'($urandom_range(0, 254));
      tb_dq_en = 1'b1;
      m_mem[wr_idx[e]] = int'(tb_dq);
    end
    c = (!cke_n || code[3]) ? C_NOP : code;
    if (r) begin
      m_ready    = 1'b0;
      busy_until = 0;
      m_open     = '0;
      for (int b = 0; b < 8; b++) begin
        m_row[b] = 0;
        m_act[b] = -100;
      end
      exp_dq.delete();
      wr_idx.delete();
      close_at.delete();
    end else begin
      if (close_at.exists(e)) m_open[close_at[e]] = 1'b0;
      if (!m_ready) begin
        if (c == C_ZQC) m_ready = 1'b1;
      end else if (e < busy_until) begin
        err = CHK && (c != C_NOP);
      end else begin
        case (c)
          C_ACT: begin
            if (CHK && m_open[ba]) err = 1'b1;
            else begin
              m_open[ba] = 1'b1;
              m_row[ba]  = addr;
              m_act[ba]  = e;
            end
          end
          C_PRE: begin
            if ((addr & 'h400) != 0) m_open = '0;
            else                     m_open[ba] = 1'b0;
          end
          C_REF: err = CHK && (m_open != 0);
          C_RD, C_WR: begin
            if (CHK && (!m_open[ba] || (e - m_act[ba]) < TRCD)) err = 1'b1;
            else begin
              lat = (c == C_RD) ? CL : CWL;
              for (int k = 0; k < 8; k++) begin
                idx = arr_index(ba, m_row[ba], addr & 'h3FF, k);
                if (c == C_RD) exp_dq[e + lat + k] = m_mem.exists(idx) ? m_mem[idx] : -1;
                else           wr_idx[e + lat + k] = idx;
              end
              busy_until = e + lat + 8;
              if ((addr & 'h400) != 0) close_at[e + lat + 7] = ba;
            end
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    check("cmd_err", {7'b0, bus.CMD_ERR}, {7'b0, err});
    check("bank_open", bus.BANK_OPEN, m_open);
    if (!tb_dq_en) begin
      if (!exp_dq.exists(e))  check("dq_idle", dq, 8'hff);
      else if (exp_dq[e] >= 0) check("dq_beat", dq, 8'(exp_dq[e]));
    end
    cyc++;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, C_NOP, 0, 0);
  endtask

  initial begin
    int op, ba, col, ap, addr;
    rst = 1'b1;
    tb_dq_en = 1'b0;
    tb_dq = '0;
    bus.CKE_N = 1'b1;
    {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N} = C_NOP;
    bus.BA = '0;
    bus.ADDR = '0;

    step(1'b1, C_NOP, 0, 0);
    step(1'b1, C_NOP, 0, 0);
    nops(1);
    // Before ZQC everything is ignored silently
    step(1'b0, C_ACT, 0, 5);
    step(1'b0, C_RD, 0, 0);
    nops(2);
    step(1'b0, C_ZQC, 0, 0);
    step(1'b0, C_MRS, 0, 0);

    // Basic write then read back, fixed data pattern
    step(1'b0, C_ACT, 2, 'h0123);
    nops(2);
    for (int k = 0; k < 8; k++) wr_data_q.push_back((k + 1) * 17);
    step(1'b0, C_WR, 2, 'h010);
    nops(12);
    step(1'b0, C_RD, 2, 'h010);
    nops(13);
    step(1'b0, C_RD, 2, 'h015);
    nops(13);

    // Read of a bank that was never activated
    step(1'b0, C_RD, 5, 'h040);
    nops(13);

    // Commands arriving during a write burst
    step(1'b0, C_WR, 2, 'h100);
    nops(2);
    step(1'b0, C_ACT, 4, 'h33);
    step(1'b0, C_REF, 0, 0);
    nops(8);
    step(1'b0, C_RD, 2, 'h100);
    nops(13);

    // Auto-precharge write then a read to the now-closed bank
    step(1'b0, C_WR, 2, 'h400 | 'h020);
    nops(12);
    step(1'b0, C_RD, 2, 'h020);
    nops(13);

    // REF with and without open banks
    step(1'b0, C_ACT, 1, 7);
    step(1'b0, C_REF, 0, 0);
    step(1'b0, C_PRE, 1, 0);
    step(1'b0, C_PRE, 1, 0);
    step(1'b0, C_REF, 0, 0);

    // tRCD boundary: reads at ACT+1, +2, +3
    step(1'b0, C_ACT, 6, 9);
    step(1'b0, C_RD, 6, 0);
    step(1'b0, C_RD, 6, 0);
    step(1'b0, C_RD, 6, 0);
    nops(13);
    step(1'b0, C_ACT, 6, 10);

    // Precharge-all after opening several banks
    step(1'b0, C_PRE, 0, 'h400);
    step(1'b0, C_ACT, 0, 1);
    step(1'b0, C_ACT, 3, 2);
    step(1'b0, C_ACT, 7, 3);
    step(1'b0, C_PRE, 0, 'h400);

    // Commands masked by CKE_N low and by CS_N high
    step(1'b0, C_ACT, 4, 4, 1'b0);
    step(1'b0, 4'b1011, 4, 4);
    step(1'b0, 4'b1001, 0, 0);

    // Randomized command mix on banks 0..3
    for (int i = 0; i < 60; i++) begin
      op  = $urandom_range(0, 9);
      ba  = $urandom_range(0, 3);
      col = $urandom_range(0, 1023);
      ap  = ($urandom_range(0, 3) == 0) ? 'h400 : 0;
      case (op)
        0, 1:    step(1'b0, C_ACT, ba, $urandom_range(0, 3));
        2:       step(1'b0, C_PRE, ba, ap);
        3, 4:    step(1'b0, C_WR, ba, col | ap);
        5, 6:    step(1'b0, C_RD, ba, col | ap);
        7:       step(1'b0, C_REF, 0, 0);
        default: step(1'b0, C_NOP, 0, 0);
      endcase
      nops($urandom_range(0, 4));
    end
    nops(16);

    // Reset on the edge of the third read beat
    step(1'b0, C_PRE, 0, 'h400);
    step(1'b0, C_ACT, 2, 'h0123);
    nops(2);
    step(1'b0, C_RD, 2, 'h010);
    nops(6);
    step(1'b1, C_NOP, 0, 0);
    step(1'b0, C_RD, 2, 'h010);
    nops(13);
    step(1'b0, C_ZQC, 0, 0);
    step(1'b0, C_ACT, 2, 'h0123);
    nops(2);
    step(1'b0, C_RD, 2, 'h010);
    nops(13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
